// File: rtl/measurement_stream_adapter.sv
// measurement_stream_adapter: strips/validates framed 64-bit host words and emits 32-bit beats, low half first.
module measurement_stream_adapter #(
    parameter logic [15:0] HEADER_MAGIC    = 16'hA5C3,
    parameter int          LEN_WIDTH       = 16,
    parameter int          FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [63:0]                s_data,
    input  logic                       s_valid,
    input  logic                       s_last,
    output logic                       s_ready,
    output logic [31:0]                m_data,
    output logic                       m_valid,
    output logic                       m_last,
    input  logic                       m_ready,
    output logic [31:0]                frame_id,
    output logic                       frame_done,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic                       err_magic,
    output logic                       err_length
);
    localparam logic [1:0] HDR = 2'd0, PAYLOAD = 2'd1, DISCARD = 2'd2;
    localparam logic [1:0] END_NONE = 2'd0, END_DONE = 2'd1, END_TRUNC = 2'd2, END_LONG = 2'd3;
    logic [1:0]           state, end_kind;
    logic [LEN_WIDTH-1:0] remaining, rem_next, len;
    logic [63:0]          word;
    logic                 full, high, ready_en, s_acc, hi_take, lo_take, magic_ok;
    // A buffered word that closes the frame blocks further intake until its high half leaves.
    always_comb begin
        len      = s_data[32 +: LEN_WIDTH];
        magic_ok = s_data[63:48] == HEADER_MAGIC;
        rem_next = remaining - 1'b1;
        hi_take  = full && high && m_ready;
        lo_take  = full && !high && m_ready;
        s_ready  = ready_en && (state != PAYLOAD || ((!full || hi_take) && end_kind == END_NONE));
        s_acc    = s_valid && s_ready;
        m_valid  = full;
        m_data   = full ? (high ? word[63:32] : word[31:0]) : '0;
        m_last   = full && high && end_kind != END_NONE;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= HDR;
            remaining   <= '0;
            word        <= '0;
            full        <= 1'b0;
            high        <= 1'b0;
            end_kind    <= END_NONE;
            ready_en    <= 1'b0;
            frame_id    <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            err_magic   <= 1'b0;
            err_length  <= 1'b0;
        end else begin
            ready_en   <= 1'b1;
            frame_done <= 1'b0;
            err_magic  <= 1'b0;
            err_length <= 1'b0;
            if (lo_take) high <= 1'b1;
            if (hi_take) begin
                full       <= 1'b0;
                high       <= 1'b0;
                end_kind   <= END_NONE;
                err_length <= end_kind == END_TRUNC || end_kind == END_LONG;
                if (end_kind == END_DONE) begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 1'b1;
                end
                if (end_kind != END_NONE) state <= end_kind == END_LONG ? DISCARD : HDR;
            end
            if (s_acc) begin
                case (state)
                    HDR: begin
                        frame_id  <= s_data[31:0];
                        remaining <= len;
                        if (!magic_ok) begin
                            err_magic <= 1'b1;
                            state     <= s_last ? HDR : DISCARD;
                        end else if (len == '0) begin
                            frame_done <= s_last;
                            err_length <= !s_last;
                            state      <= s_last ? HDR : DISCARD;
                            if (s_last) frame_count <= frame_count + 1'b1;
                        end else if (s_last) begin
                            err_length <= 1'b1;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        word      <= s_data;
                        full      <= 1'b1;
                        high      <= 1'b0;
                        remaining <= rem_next;
                        end_kind  <= s_last ? (rem_next == '0 ? END_DONE : END_TRUNC)
                                            : (rem_next == '0 ? END_LONG : END_NONE);
                    end
                    default: if (s_last) state <= HDR;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_measurement_stream_adapter.sv
// tb_measurement_stream_adapter: random and directed frames checked against a word-level reference model.
module tb_measurement_stream_adapter;
    logic        clk = 1'b0, reset = 1'b0;
    logic [63:0] s_data = '0;
    logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic [31:0] m_data, frame_id;
    logic        m_valid, m_last, m_ready = 1'b0;
    logic        frame_done, err_magic, err_length;
    logic [15:0] frame_count;

    measurement_stream_adapter dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .frame_id(frame_id),
        .frame_done(frame_done), .frame_count(frame_count), .err_magic(err_magic), .err_length(err_length)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_data [4096];
    logic        exp_last [4096];
    int          exp_wr = 0, rd = 0;
    int          mst = 0, mrem = 0, m_fd = 0, m_em = 0, m_el = 0;
    logic [15:0] m_cnt = '0;
    logic [31:0] m_id = '0;
    int          o_fd = 0, o_em = 0, o_el = 0;
    int          rdy_mode = 1, gaps = 0, tog = 0;

    task automatic push_beat(input logic [31:0] d, input logic l);
        exp_data[exp_wr % 4096] = d;
        exp_last[exp_wr % 4096] = l;
        exp_wr++;
    endtask

    // Reference: mst 0 = expecting header, 1 = in payload, 2 = skipping to s_last.
    task automatic model_word(input logic [63:0] w, input logic l);
        int len;
        len = int'(w[47:32]);
        if (mst == 0) begin
            m_id = w[31:0];
            mrem = len;
            if (w[63:48] != 16'hA5C3) begin m_em++; mst = l ? 0 : 2; end
            else if (len == 0) begin
                if (l) begin m_fd++; m_cnt++; end
                else begin m_el++; mst = 2; end
            end
            else if (l) m_el++;
            else mst = 1;
        end else if (mst == 1) begin
            mrem--;
            push_beat(w[31:0], 1'b0);
            push_beat(w[63:32], l || mrem == 0);
            if (l) begin
                if (mrem == 0) begin m_fd++; m_cnt++; end
                else m_el++;
                mst = 0;
            end else if (mrem == 0) begin
                m_el++;
                mst = 2;
            end
        end else if (l) mst = 0;
    endtask

    always @(posedge clk) begin
        #1;
        tog = (tog + 1) % 3;
        m_ready = rdy_mode == 0 ? 1'($urandom_range(0, 1)) : rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'b0 : (tog == 0);
    end

    logic        stall = 1'b0, par = 1'b0, st_last = 1'b0;
    logic [31:0] st_data = '0;
    always @(negedge clk) begin
        if (!reset) begin
            stall = 1'b0;
            par   = 1'b0;
            rd    = exp_wr;
        end else begin
            if (stall) begin
                check("stall_valid", 64'(m_valid), 64'd1);
                check("stall_data", 64'(m_data), 64'(st_data));
                check("stall_last", 64'(m_last), 64'(st_last));
            end
            stall = 1'b0;
            if (frame_done || err_magic || err_length)
                check("pulse_excl", 64'(int'(frame_done) + int'(err_magic) + int'(err_length)), 64'd1);
            o_fd += int'(frame_done);
            o_em += int'(err_magic);
            o_el += int'(err_length);
            if (m_valid) begin
                if (!par) check("sready_low_half", 64'(s_ready), 64'd0);
                if (m_ready) begin
                    if (rd == exp_wr) check("extra_beat", 64'd1, 64'd0);
                    else begin
                        check("beat_data", 64'(m_data), 64'(exp_data[rd % 4096]));
                        check("beat_last", 64'(m_last), 64'(exp_last[rd % 4096]));
                        rd++;
                    end
                    par = !par;
                end else begin
                    stall   = 1'b1;
                    st_data = m_data;
                    st_last = m_last;
                end
            end
        end
    end

    task automatic send_word(input logic [63:0] w, input logic l);
        int n = 0;
        if (gaps != 0 && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
        s_data  = w;
        s_last  = l;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 200) begin n++; @(negedge clk); end
        if (s_ready) begin
            @(posedge clk); #1;
            s_valid = 1'b0;
            model_word(w, l);
        end else begin
            s_valid = 1'b0;
            check("accept_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [15:0] magic, input int len, input logic [31:0] id, input int nw);
        send_word({magic, 16'(len), id}, nw == 0);
        for (int i = 0; i < nw; i++) send_word({$urandom, $urandom}, i == nw - 1);
    endtask

    task automatic drain_and_verify();
        int n = 0;
        while ((rd != exp_wr || m_valid) && n < 400) begin @(posedge clk); #1; n++; end
        if (n == 400) check("drain_timeout", 64'd0, 64'd1);
        repeat (3) begin @(posedge clk); #1; end
        check("frame_done_total", 64'(o_fd), 64'(m_fd));
        check("err_magic_total", 64'(o_em), 64'(m_em));
        check("err_length_total", 64'(o_el), 64'(m_el));
        check("frame_count", 64'(frame_count), 64'(m_cnt));
        check("frame_id", 64'(frame_id), 64'(m_id));
    endtask

    task automatic check_reset();
        check("reset_ctl", 64'({s_ready, m_valid, m_last, frame_done, err_magic, err_length}), 64'd0);
        check("reset_data", 64'(m_data), 64'd0);
        check("reset_id", 64'(frame_id), 64'd0);
        check("reset_count", 64'(frame_count), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, len, nw;
        logic [15:0] magic;
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        reset = 1'b1;
        send_word(64'hA5C3_0002_1234_5678, 1'b0);
        send_word(64'h1111_2222_3333_4444, 1'b0);
        send_word(64'h5555_6666_7777_8888, 1'b1);
        drain_and_verify();
        check("good_id_const", 64'(frame_id), 64'h1234_5678);
        check("good_count_const", 64'(frame_count), 64'd1);
        rdy_mode = 3;
        send_frame(16'hA5C3, 2, 32'h0BAD_F00D, 2);
        drain_and_verify();
        rdy_mode = 0;
        send_frame(16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF, 3);
        send_frame(16'hA5C3, 2, 32'h0000_0042, 2);
        drain_and_verify();
        send_frame(16'hA5C3, 3, 32'h0000_0007, 1);
        drain_and_verify();
        send_frame(16'hA5C3, 1, 32'h0000_0011, 3);
        send_frame(16'hA5C3, 0, 32'h0000_0022, 0);
        drain_and_verify();
        rdy_mode = 2;
        send_word(64'hA5C3_0002_0000_0033, 1'b0);
        send_word(64'hCAFE_0001_BEEF_0002, 1'b0);
        n = 0;
        while (!m_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("first_beat_seen", 64'(m_valid), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check_reset();
        mst = 0; m_cnt = '0; m_id = '0;
        rdy_mode = 1;
        send_frame(16'hA5C3, 2, 32'h0000_0044, 2);
        drain_and_verify();
        check("count_after_reset", 64'(frame_count), 64'd1);
        rdy_mode = 0;
        gaps = 1;
        for (int f = 0; f < 40; f++) begin
            magic = $urandom_range(0, 7) == 0 ? 16'($urandom) : 16'hA5C3;
            len = int'($urandom_range(0, 4));
            nw = len;
            if ($urandom_range(0, 3) == 0) nw = len + int'($urandom_range(0, 2)) - 1;
            if (nw < 0) nw = 0;
            send_frame(magic, len, $urandom, nw);
            if (f % 8 == 7) drain_and_verify();
        end
        drain_and_verify();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/measurement_stream_adapter.md
Name: measurement_stream_adapter

Overview:
- Upstream neighbour of the single-FPGA decoder core. Converts the 64-bit framed host syndrome stream into the 32-bit valid/ready measurement stream on the core's input_data/input_valid/input_ready port.
- Per frame: parses and strips the header, validates the magic and length, splits each payload word into two 32-bit beats (low half first), flags the last beat, and counts completed frames.
- Framing errors are reported through pulses; the frame's remaining words are discarded and no partial data is delivered past the error point.

Parameters:
- HEADER_MAGIC, 16'hA5C3: required value of header bits [63:48].
- LEN_WIDTH, 16: width of the payload-length field, header bits [47:32]; must be ≤16.
- FRAME_CNT_WIDTH, 16: width of the completed-frame counter.

Ports:
- clk  in  1: single clock.
- reset  in  1: synchronous, active-low reset.
- s_data  in  64: host word.
- s_valid  in  1: host word valid.
- s_last  in  1: marks the final word of a host frame.
- s_ready  out  1: adapter accepts s_data this cycle.
- m_data  out  32: measurement beat to the decoder core.
- m_valid  out  1: beat valid.
- m_last  out  1: last beat of the frame payload.
- m_ready  in  1: core accepts the beat.
- frame_id  out  32: header bits [31:0] of the frame in progress. Updated when the header is accepted.
- frame_done  out  1: one-cycle pulse when a frame completes without error.
- frame_count  out  FRAME_CNT_WIDTH: count of error-free frames; wraps modulo 2^FRAME_CNT_WIDTH.
- err_magic  out  1: one-cycle pulse when a header is rejected.
- err_length  out  1: one-cycle pulse on a length/s_last mismatch.

Behaviour:
- Reset applies when reset=0 at a rising edge. The following are 0 after reset: s_ready, m_valid, m_last, m_data, frame_id, frame_done, frame_count, err_*. The buffer empties and the FSM enters HDR. Reset mid-frame drops all buffered and in-flight data.
- Handshake:
  - A transfer occurs when valid&&ready on a rising edge.
  - m_valid, once asserted, holds m_data and m_last stable until m_ready.
  - s_ready is registered-free combinational: 1 in HDR and DISCARD. In PAYLOAD it is 1 when the buffer is empty, or when it holds the high half and m_ready=1.
- FSM states:
  - HDR: s_ready=1, no output.
    - On header accept, latch frame_id and remaining=len.
    - If magic≠HEADER_MAGIC: pulse err_magic. Go to DISCARD unless s_last=1, in which case stay in HDR.
    - If magic is good and len=0: a header with s_last=1 pulses frame_done, increments frame_count, and stays in HDR. A header with s_last=0 pulses err_length and goes to DISCARD.
    - If magic is good and len>0 with s_last=1: pulse err_length and stay in HDR.
    - Otherwise go to PAYLOAD.
  - PAYLOAD:
    - An accepted word loads the 64-bit buffer and decrements remaining.
    - m_data=word[31:0] in the cycle after the accept, then word[63:32] after that beat is taken.
    - m_last=1 on the high half of the word that brings remaining to 0, provided s_last=1 on that word.
    - After that high half is taken: pulse frame_done, increment frame_count, go to HDR.
  - DISCARD: s_ready=1, no output. Leaves for HDR on an accepted word with s_last=1.
- Length rules:
  - s_last=1 on a word while remaining>1 (truncated frame): that word's two beats are forwarded with m_last=1 on the high half. When the high half is taken, pulse err_length (no frame_done, no count) and go to HDR.
  - remaining reaches 0 with s_last=0 (overlong frame): both halves are forwarded with m_last=1. Then pulse err_length and go to DISCARD.
- Throughput and latency:
  - Steady state with m_ready=1: one host word per 2 cycles, one beat per cycle.
  - First beat latency is 1 cycle after the payload-word accept.
  - A header can be accepted in the same cycle the previous frame's final high half is taken. No bubble is required, but a 1-cycle bubble is allowed.
- frame_count wraps from all-ones to 0 with no flag.
- frame_done and err_* are never asserted in the same cycle.

Test Plan:
- Good frame: header {A5C3, len=2, id=0x1234_5678}, payload 0x1111_2222_3333_4444 and 0x5555_6666_7777_8888 (s_last on the second), m_ready=1 → beats 3333_4444, 1111_2222, 7777_8888, 5555_6666 on 4 consecutive cycles; m_last only on 5555_6666; frame_done pulses once; frame_count=1; frame_id=0x12345678.
- Backpressure: same frame with m_ready toggling 1,0,0,1,… → no beat lost or duplicated, m_data stable while stalled, s_ready=0 while the buffer holds an untaken low half.
- Bad magic: header 0xFFFF… followed by 3 words, s_last on the third → err_magic pulses once; no m_valid ever; next good frame is decoded normally.
- Truncated: len=3 with s_last on the first payload word → 2 beats, m_last on the second; err_length pulses; frame_count unchanged.
- Overlong and len=0: len=1 with 3 payload words → 2 beats, err_length, the remaining 2 words are discarded. A len=0 header with s_last=1 → frame_done pulses with zero beats.
- Reset mid-frame (reset=0 for 1 cycle after the first beat) → all outputs 0 next cycle; the following good frame produces a correct count starting from 1.
